// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard for outstanding cache loads.
// Reads are combinational and forward an accepted load response in the same cycle;
// writebacks, load issues and load responses all commit on the rising clock edge.
module reg_file_sb #(
  parameter int N        = 32,
  parameter int NREG     = 32,
  parameter int MAX_PEND = 4,
  parameter int AW       = $clog2(NREG),
  parameter int CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    write_sel,
  input  logic [AW-1:0] rd,
  input  logic [N-1:0]  wdata,
  input  logic [N-1:0]  pc_plus_four,
  input  logic [N-1:0]  external_input,
  input  logic          load_issue,
  input  logic          resp_valid,
  input  logic [AW-1:0] resp_rd,
  input  logic [N-1:0]  resp_data,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic [N-1:0]  data1,
  output logic [N-1:0]  data2,
  output logic          busy1,
  output logic          busy2,
  output logic          hazard,
  output logic          pend_full,
  output logic [CW-1:0] pend_count,
  output logic          resp_err
);

  logic [N-1:0]    gpr [NREG];
  logic [NREG-1:0] busy;

  logic          wr_valid;
  logic [N-1:0]  wr_value;
  logic          resp_acc;
  logic          rd_free;
  logic          issue_acc;
  logic          wb_en;
  logic          fwd1;
  logic          fwd2;

  // Only the three legal one-hot codes select a writeback source.
  function automatic logic onehot_valid(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

  // Source mux for the writeback value; unused codes never reach the array.
  function automatic logic [N-1:0] wb_mux(input logic [2:0] sel, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic [N-1:0] c);
    logic [N-1:0] v;
    v = '0;
    case (sel)
      3'b001:  v = a;
      3'b010:  v = b;
      3'b100:  v = c;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign pend_full = (pend_count == CW'(MAX_PEND));

  // Accept decisions: a response frees a slot and, for the same register, lets a
  // new load to that register be issued in the same cycle.
  always_comb begin
    wr_valid  = onehot_valid(write_sel);
    wr_value  = wb_mux(write_sel, wdata, pc_plus_four, external_input);
    resp_acc  = resp_valid && (resp_rd != '0) && busy[resp_rd];
    rd_free   = !busy[rd] || (resp_acc && (resp_rd == rd));
    issue_acc = load_issue && (rd != '0) && rd_free && (!pend_full || resp_acc);
    // WAW check uses the busy bit as it stands, so a same-cycle response to rd
    // still blocks the writeback.
    wb_en     = wr_valid && !load_issue && (rd != '0) && !busy[rd];
    hazard    = (wr_valid && !load_issue && (rd != '0) && busy[rd]) ||
                (load_issue && (rd != '0) && !issue_acc);
  end

  // Read ports with same-cycle forwarding of an accepted load response.
  always_comb begin
    fwd1  = resp_acc && (resp_rd == rs1);
    fwd2  = resp_acc && (resp_rd == rs2);
    data1 = '0;
    data2 = '0;
    if (fwd1)            data1 = resp_data;
    else if (rs1 != '0)  data1 = gpr[rs1];
    if (fwd2)            data2 = resp_data;
    else if (rs2 != '0)  data2 = gpr[rs2];
    busy1 = busy[rs1] && !fwd1;
    busy2 = busy[rs2] && !fwd2;
  end

  // Register array: load responses and writebacks never target the same entry
  // because one requires the register busy and the other requires it idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else begin
      if (resp_acc) gpr[resp_rd] <= resp_data;
      if (wb_en)    gpr[rd]      <= wr_value;
    end
  end

  // Busy scoreboard: clear on response first, then set on issue so a
  // same-register response+issue leaves the register pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      logic [NREG-1:0] nb;
      nb = busy;
      if (resp_acc)  nb[resp_rd] = 1'b0;
      if (issue_acc) nb[rd]      = 1'b1;
      nb[0] = 1'b0;
      busy <= nb;
    end
  end

  // Outstanding-load counter; issue and response in one cycle cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_count <= '0;
    end else if (issue_acc && !resp_acc) begin
      pend_count <= pend_count + CW'(1);
    end else if (resp_acc && !issue_acc) begin
      pend_count <= pend_count - CW'(1);
    end
  end

  // Sticky flag for responses that matched no outstanding load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_err <= 1'b0;
    end else if (resp_valid && !resp_acc) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Table-driven bench for reg_file_sb: each vector drives one cycle of inputs and
// records the outputs expected before the next clock edge.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  write_sel;
  logic [4:0]  rd, resp_rd, rs1, rs2;
  logic [31:0] wdata, pc_plus_four, external_input, resp_data;
  logic        load_issue, resp_valid;
  logic [31:0] data1, data2;
  logic        busy1, busy2, hazard, pend_full, resp_err;
  logic [2:0]  pend_count;

  typedef struct packed {
    logic [2:0]  ws;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [31:0] ext;
    logic        li;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdat;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        hz;
    logic        pf;
    logic [2:0]  pc;
    logic        re;
  } vec_t;

  vec_t vecs [29];
  vec_t post [5];
  vec_t sb_q [$];
  int   n_vec = 0;
  int   n_bad = 0;

  reg_file_sb #(.N(32), .NREG(32), .MAX_PEND(4)) dut (
    .clk(clk), .reset(reset), .write_sel(write_sel), .rd(rd), .wdata(wdata),
    .pc_plus_four(pc_plus_four), .external_input(external_input),
    .load_issue(load_issue), .resp_valid(resp_valid), .resp_rd(resp_rd),
    .resp_data(resp_data), .rs1(rs1), .rs2(rs2), .data1(data1), .data2(data2),
    .busy1(busy1), .busy2(busy2), .hazard(hazard), .pend_full(pend_full),
    .pend_count(pend_count), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    write_sel      = v.ws;
    rd             = v.rd;
    wdata          = v.wd;
    pc_plus_four   = v.pc4;
    external_input = v.ext;
    load_issue     = v.li;
    resp_valid     = v.rv;
    resp_rd        = v.rrd;
    resp_data      = v.rdat;
    rs1            = v.rs1;
    rs2            = v.rs2;
    sb_q.push_back(v);
  endtask

  task automatic check(input string name, input int idx);
    vec_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s[%0d]: scoreboard empty, got no expected entry, required one", name, idx);
      return;
    end
    e = sb_q.pop_front();
    if (data1 !== e.d1 || data2 !== e.d2 || busy1 !== e.b1 || busy2 !== e.b2 ||
        hazard !== e.hz || pend_full !== e.pf || pend_count !== e.pc || resp_err !== e.re) begin
      n_bad++;
      $display("FAIL %s[%0d]: got d1=%h d2=%h b1=%b b2=%b hz=%b pf=%b pc=%0d re=%b required d1=%h d2=%h b1=%b b2=%b hz=%b pf=%b pc=%0d re=%b",
               name, idx, data1, data2, busy1, busy2, hazard, pend_full, pend_count, resp_err,
               e.d1, e.d2, e.b1, e.b2, e.hz, e.pf, e.pc, e.re);
    end
  endtask

  task automatic apply(input string name, input int idx, input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check(name, idx);
  endtask

  initial begin
    vec_t rv_chk;
    //          ws rd wd            pc4        ext         li rv rrd rdat          rs1 rs2 | d1            d2            b1 b2 hz pf pc re
    vecs[0]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            0,  0,   0,            0,            0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 5, 32'hDEADBEEF, 0,         0,          0, 0, 0,  0,            5,  0,   0,            0,            0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            5,  0,   32'hDEADBEEF, 0,            0, 0, 0, 0, 0, 0};
    vecs[3]  = '{2, 8, 0,            32'h100,   0,          0, 0, 0,  0,            5,  8,   32'hDEADBEEF, 0,            0, 0, 0, 0, 0, 0};
    vecs[4]  = '{4, 10, 0,           0,         32'hCAFE,   0, 0, 0,  0,            8,  10,  32'h100,      0,            0, 0, 0, 0, 0, 0};
    vecs[5]  = '{3, 11, 32'h55,      0,         0,          0, 0, 0,  0,            10, 11,  32'hCAFE,     0,            0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 32'h77,       0,         0,          0, 0, 0,  0,            11, 0,   0,            0,            0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            0,  0,   0,            0,            0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 0,            0,         0,          1, 0, 0,  0,            1,  5,   0,            32'hDEADBEEF, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 2, 0,            0,         0,          1, 0, 0,  0,            1,  2,   0,            0,            1, 0, 0, 0, 1, 0};
    vecs[10] = '{1, 3, 32'h99,       0,         0,          1, 0, 0,  0,            2,  3,   0,            0,            1, 0, 0, 0, 2, 0};
    vecs[11] = '{0, 4, 0,            0,         0,          1, 0, 0,  0,            3,  4,   0,            0,            1, 0, 0, 0, 3, 0};
    vecs[12] = '{0, 6, 0,            0,         0,          1, 0, 0,  0,            4,  6,   0,            0,            1, 0, 1, 1, 4, 0};
    vecs[13] = '{0, 6, 0,            0,         0,          1, 1, 1,  32'h1111,     6,  1,   0,            32'h1111,     0, 0, 0, 1, 4, 0};
    vecs[14] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            6,  1,   0,            32'h1111,     1, 0, 0, 1, 4, 0};
    vecs[15] = '{0, 2, 0,            0,         0,          1, 0, 0,  0,            2,  3,   0,            0,            1, 1, 1, 1, 4, 0};
    vecs[16] = '{1, 3, 32'hBAD,      0,         0,          0, 0, 0,  0,            3,  0,   0,            0,            1, 0, 1, 1, 4, 0};
    vecs[17] = '{2, 3, 0,            32'h4444,  0,          0, 1, 3,  32'h3333,     3,  0,   32'h3333,     0,            0, 0, 1, 1, 4, 0};
    vecs[18] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            3,  4,   32'h3333,     0,            0, 1, 0, 0, 3, 0};
    vecs[19] = '{0, 4, 0,            0,         0,          1, 1, 4,  32'h4040,     4,  0,   32'h4040,     0,            0, 0, 0, 0, 3, 0};
    vecs[20] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            4,  2,   32'h4040,     0,            1, 1, 0, 0, 3, 0};
    vecs[21] = '{0, 0, 0,            0,         0,          0, 1, 5,  32'hFFFF,     5,  0,   32'hDEADBEEF, 0,            0, 0, 0, 0, 3, 0};
    vecs[22] = '{0, 0, 0,            0,         0,          0, 1, 0,  32'h1,        5,  0,   32'hDEADBEEF, 0,            0, 0, 0, 0, 3, 1};
    vecs[23] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            5,  0,   32'hDEADBEEF, 0,            0, 0, 0, 0, 3, 1};
    vecs[24] = '{0, 7, 0,            0,         0,          1, 0, 0,  0,            7,  0,   0,            0,            0, 0, 0, 0, 3, 1};
    vecs[25] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            7,  0,   0,            0,            1, 0, 0, 1, 4, 1};
    vecs[26] = '{0, 0, 0,            0,         0,          0, 1, 7,  32'h12345678, 7,  0,   32'h12345678, 0,            0, 0, 0, 1, 4, 1};
    vecs[27] = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            7,  0,   32'h12345678, 0,            0, 0, 0, 0, 3, 1};
    vecs[28] = '{0, 0, 0,            0,         0,          0, 1, 6,  32'h66,       6,  2,   32'h66,       0,            0, 1, 0, 0, 3, 1};
    // Reset with r2 and r4 still pending, then a stale response and a fresh issue.
    post[0]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            2,  5,   0,            0,            0, 0, 0, 0, 0, 0};
    post[1]  = '{0, 0, 0,            0,         0,          0, 1, 2,  32'hAB,       2,  4,   0,            0,            0, 0, 0, 0, 0, 0};
    post[2]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            2,  1,   0,            0,            0, 0, 0, 0, 0, 1};
    post[3]  = '{0, 2, 0,            0,         0,          1, 0, 0,  0,            2,  0,   0,            0,            0, 0, 0, 0, 0, 1};
    post[4]  = '{0, 0, 0,            0,         0,          0, 0, 0,  0,            2,  0,   0,            0,            1, 0, 0, 0, 1, 1};

    reset = 1'b1;
    rv_chk = vecs[0];
    drive(rv_chk);
    void'(sb_q.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) apply("vec", i, vecs[i]);

    // Asynchronous reset between edges: state must clear before any clock.
    @(posedge clk);
    #1;
    drive(post[0]);
    reset = 1'b1;
    #1;
    check("async_reset", 0);
    #1;
    reset = 1'b0;

    for (int i = 1; i < 5; i++) apply("post_reset", i, post[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter N, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: number of registers; AW = $clog2(NREG).
REQ-003 SHALL have parameter MAX_PEND, default 4: max outstanding cache loads; CW = $clog2(MAX_PEND+1).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- write_sel  in  3  one-hot writeback source: 001 = wdata, 010 = pc_plus_four, 100 = external_input; other values = no write.
- rd  in  AW  writeback / load destination.
- wdata, pc_plus_four, external_input  in  N  writeback sources.
- load_issue  in  1  request to mark rd pending for a cache load.
- resp_valid  in  1  cache load data return.
- resp_rd  in  AW  load return destination.
- resp_data  in  N  load return data.
- rs1, rs2  in  AW  read addresses.
- data1, data2  out  N  read data.
- busy1, busy2  out  1  read operand pending.
- hazard  out  1  current write_sel or load_issue rejected.
- pend_full  out  1  pend_count == MAX_PEND.
- pend_count  out  CW  outstanding loads.
- resp_err  out  1  sticky: unmatched response seen.

Function
REQ-005 SHALL hold NREG x N registers plus an NREG-bit busy vector; register 0 reads 0, is never busy, and ignores all writes, issues and responses.
REQ-006 SHALL read asynchronously: data1 = resp_data when resp_valid, resp_rd == rs1, rs1 != 0 and busy[rs1]; otherwise gpr[rs1], or 0 for rs1 == 0. data2/rs2 identical.
REQ-007 SHALL drive busy1 = busy[rs1] & !(resp_valid & resp_rd == rs1 accepted); busy2 identical.
REQ-008 SHALL accept a load issue when load_issue = 1, rd != 0, busy[rd] = 0 and pend_full = 0, or when pend_full = 1 and an accepted response arrives the same cycle; accepted issue sets busy[rd] at the next edge.
REQ-009 SHALL accept a response when resp_valid = 1, resp_rd != 0 and busy[resp_rd] = 1: write resp_data to gpr[resp_rd] and clear busy[resp_rd] at the next edge.
REQ-010 SHALL treat an unaccepted response (target not busy, or resp_rd = 0) as a no-op except setting resp_err, which stays 1 until reset.
REQ-011 SHALL perform a writeback at the edge when write_sel is a valid one-hot code, load_issue = 0, rd != 0 and busy[rd] = 0.
REQ-012 SHALL suppress the writeback and assert hazard when the write targets a busy register (WAW), even if a response to that register arrives the same cycle.
REQ-013 SHALL ignore write_sel whenever load_issue = 1 (issue has priority; no hazard for the ignored write).
REQ-014 SHALL assert hazard combinationally when load_issue = 1, rd != 0 and the issue is not accepted.
REQ-015 SHALL update pend_count each edge: +1 for accepted issue only, -1 for accepted response only, unchanged for both or neither; it never exceeds MAX_PEND or wraps below 0.
REQ-016 SHALL, when an accepted response and accepted issue name the same register in one cycle, write resp_data and leave busy = 1 (new load pending).
REQ-017 SHALL give single-cycle latency: all state visible on outputs after the edge on which it is written.

Reset
REQ-018 SHALL, on reset = 1 (asynchronous, any cycle, including with loads outstanding), clear all registers to 0, the busy vector to 0, pend_count to 0 and resp_err to 0.
REQ-019 SHALL drop responses for loads issued before reset, flagging them per REQ-010.

Verification
REQ-020 Reset; write_sel = 001, rd = 5, wdata = 0xDEADBEEF; next cycle rs1 = 5 -> data1 = 0xDEADBEEF, busy1 = 0; rs2 = 0 -> data2 = 0.
REQ-021 Issue loads to r1..r4 with MAX_PEND = 4 -> pend_count = 4, pend_full = 1; issue r6 -> hazard = 1, busy[6] stays 0; issue r6 with resp to r1 in the same cycle -> accepted, pend_count stays 4.
REQ-022 r7 pending; rs1 = 7 -> busy1 = 1; resp_rd = 7, resp_data = 0x12345678 -> same cycle data1 = 0x12345678, busy1 = 0; next cycle gpr[7] = 0x12345678, pend_count decremented.
REQ-023 r9 pending; write_sel = 010, rd = 9 with resp to r9 -> hazard = 1; gpr[9] = resp_data, not pc_plus_four.
REQ-024 resp_valid with resp_rd = 3 not busy -> gpr[3] unchanged, resp_err = 1 and held; assert reset mid-run with 2 loads pending -> pend_count = 0, busy clear, resp_err = 0 immediately.
